four_way_mux_arbiter: RTL and testbench

Round-robin arbiter that shares the 4-to-1 one-bit mux between four requesters. It registers a one-hot grant and drives the mux `selector_bits` so that the granted requester's line reaches `output_line`. A per-grant hold limit stops any one requester from monopolising the mux while others wait.

---
 rtl/four_way_mux_arbiter.sv | 127 ++++++++++++
 tb/tb_four_way_mux_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/four_way_mux_arbiter.sv
// Round-robin arbiter sharing a 4-to-1 one-bit mux between four requesters,
// with a per-grant hold limit that forces rotation under contention.

module four_way_mux_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] request_lines,
    output logic [3:0] grant_lines,
    output logic       grant_valid,
    output logic [1:0] selector_bits,
    output logic [7:0] hold_count
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] last_q;
    logic [1:0] last_d;
    logic [1:0] sel_d;
    logic [7:0] hold_d;
    logic [3:0] grant_d;
    logic       valid_d;

    logic [3:0] others;
    logic [3:0] candidates;
    logic       pick_found;
    logic [1:0] pick_idx;
    logic [1:0] probe;

    // In GRANT last_q equals the current index, so one search from last_q+1
    // serves both the idle-start and the handover cases.
    always_comb begin
        others     = request_lines & ~(4'b0001 << selector_bits);
        candidates = (state_q == GRANT) ? others : request_lines;
        pick_found = 1'b0;
        pick_idx   = last_q;
        probe      = last_q;
        for (int unsigned i = 1; i <= 4; i++) begin
            probe = last_q + 2'(i);
            if (!pick_found && candidates[probe]) begin
                pick_found = 1'b1;
                pick_idx   = probe;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            last_q        <= 2'd3;
            grant_lines   <= '0;
            grant_valid   <= 1'b0;
            selector_bits <= '0;
            hold_count    <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            grant_lines   <= grant_d;
            grant_valid   <= valid_d;
            selector_bits <= sel_d;
            hold_count    <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = selector_bits;
        hold_d  = hold_count;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    last_d  = pick_idx;
                    sel_d   = pick_idx;
                    hold_d  = 8'd1;
                end
            end
            GRANT: begin
                // Release and hold-limit expiry share one path: rotate if anyone else waits.
                if (!request_lines[selector_bits] ||
                    ((hold_count >= HOLD_LIMIT) && (others != 4'b0000))) begin
                    if (pick_found) begin
                        last_d = pick_idx;
                        sel_d  = pick_idx;
                        hold_d = 8'd1;
                    end else begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end
                end else if (hold_count < HOLD_LIMIT) begin
                    hold_d = hold_count + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d = '0;
        valid_d = 1'b0;
        if (state_d == GRANT) begin
            grant_d = 4'b0001 << sel_d;
            valid_d = 1'b1;
        end
    end

endmodule

// Shared 4-to-1 one-bit mux steered by the arbiter's selector_bits.
module four_to_one_mux (
    input  logic [3:0] input_lines,
    input  logic [1:0] selector_bits,
    output logic       output_line
);

    assign output_line = input_lines[selector_bits];

endmodule

// File: tb/tb_four_way_mux_arbiter.sv
// Randomized and directed bench for four_way_mux_arbiter against a behavioural
// round-robin model; two instances with different hold limits share stimulus.

module tb_four_way_mux_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] request_lines;
    logic [3:0] input_lines;

    logic [3:0] g0, g1;
    logic       v0, v1;
    logic [1:0] s0, s1;
    logic [7:0] h0, h1;
    logic       o0, o1;

    int checks = 0;
    int errors = 0;

    bit m_busy[2];
    int m_cur[2];
    int m_hold[2];
    int m_last[2];
    int m_sel[2];
    int m_max[2] = '{2, 5};

    four_way_mux_arbiter #(.MAX_HOLD(2)) dut0 (
        .clk(clk), .reset(reset), .request_lines(request_lines),
        .grant_lines(g0), .grant_valid(v0), .selector_bits(s0), .hold_count(h0)
    );

    four_way_mux_arbiter #(.MAX_HOLD(5)) dut1 (
        .clk(clk), .reset(reset), .request_lines(request_lines),
        .grant_lines(g1), .grant_valid(v1), .selector_bits(s1), .hold_count(h1)
    );

    four_to_one_mux mux0 (.input_lines(input_lines), .selector_bits(s0), .output_line(o0));
    four_to_one_mux mux1 (.input_lines(input_lines), .selector_bits(s1), .output_line(o1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_busy[n] = 1'b0;
            m_cur[n]  = 0;
            m_hold[n] = 0;
            m_last[n] = 3;
            m_sel[n]  = 0;
        end
    endtask

    // Whoever first wants the mux, looking round from the index after 'from'.
    function automatic int first_after(input int from, input logic [3:0] want);
        for (int k = 1; k <= 4; k++) begin
            if (want[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(input int n, input logic [3:0] req);
        logic [3:0] others;
        int pick;
        if (!m_busy[n]) begin
            pick = first_after(m_last[n], req);
            if (pick >= 0) begin
                m_busy[n] = 1'b1;
                m_cur[n]  = pick;
                m_last[n] = pick;
                m_sel[n]  = pick;
                m_hold[n] = 1;
            end
        end else begin
            others = req;
            others[m_cur[n]] = 1'b0;
            if (!req[m_cur[n]] || (m_hold[n] == m_max[n] && others != 0)) begin
                pick = first_after(m_cur[n], others);
                if (pick >= 0) begin
                    m_cur[n]  = pick;
                    m_last[n] = pick;
                    m_sel[n]  = pick;
                    m_hold[n] = 1;
                end else begin
                    m_busy[n] = 1'b0;
                end
            end else if (m_hold[n] < m_max[n]) begin
                m_hold[n]++;
            end
        end
    endtask

    task automatic compare_inst(input int n, input logic [3:0] g, input logic v,
                                input logic [1:0] s, input logic [7:0] h, input logic o);
        logic [3:0] exp_g;
        exp_g = m_busy[n] ? (4'b0001 << m_cur[n]) : 4'b0000;
        check($sformatf("d%0d_grant", n), 32'(g), 32'(exp_g));
        check($sformatf("d%0d_valid", n), 32'(v), 32'(m_busy[n]));
        check($sformatf("d%0d_sel", n), 32'(s), 32'(m_sel[n]));
        if (m_busy[n]) check($sformatf("d%0d_hold", n), 32'(h), 32'(m_hold[n]));
        check($sformatf("d%0d_mux", n), 32'(o), 32'(input_lines[m_sel[n]]));
    endtask

    task automatic cycle(input logic [3:0] req);
        request_lines = req;
        @(posedge clk);
        model_step(0, req);
        model_step(1, req);
        @(negedge clk);
        compare_inst(0, g0, v0, s0, h0, o0);
        compare_inst(1, g1, v1, s1, h1, o1);
    endtask

    task automatic async_reset_pulse();
        #2 reset = 1'b1;
        #1;
        check("async_rst_g0", 32'(g0), 32'h0);
        check("async_rst_g1", 32'(g1), 32'h0);
        check("async_rst_v0", 32'(v0), 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] req;
        reset         = 1'b1;
        request_lines = 4'b1111;
        input_lines   = 4'b1010;
        model_reset();

        @(negedge clk);
        @(negedge clk);
        check("rst_grant", 32'(g0), 32'h0);
        check("rst_valid", 32'(v0), 32'h0);
        check("rst_sel", 32'(s0), 32'h0);
        check("rst_hold", 32'(h0), 32'h0);
        reset = 1'b0;

        // Full contention on the MAX_HOLD=2 instance: each requester holds two cycles.
        for (int k = 1; k <= 10; k++) begin
            cycle(4'b1111);
            check("rr_grant", 32'(g0), 32'(4'b0001 << (((k - 1) / 2) % 4)));
            check("rr_hold", 32'(h0), 32'(((k - 1) % 2) + 1));
            check("rr_mux", 32'(o0), 32'((((k - 1) / 2) % 4) % 2));
        end

        cycle(4'b0110);
        check("handover_pre", 32'(g0), 32'h2);
        cycle(4'b0100);
        check("handover_grant", 32'(g0), 32'h4);
        check("handover_sel", 32'(s0), 32'h2);
        check("handover_valid", 32'(v0), 32'h1);

        for (int k = 1; k <= 10; k++) begin
            cycle(4'b1000);
            check("solo_grant", 32'(g0), 32'h8);
            check("solo_hold", 32'(h0), 32'((k < 2) ? k : 2));
        end
        cycle(4'b0000);
        check("idle_valid", 32'(v0), 32'h0);
        check("idle_sel", 32'(s0), 32'h3);

        cycle(4'b0100);
        check("pre_rst_grant", 32'(g0), 32'h4);
        async_reset_pulse();
        cycle(4'b1100);
        check("post_rst_grant", 32'(g0), 32'h4);

        req = 4'b0000;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) req[$urandom_range(0, 3)] = ~req[$urandom_range(0, 3)];
            input_lines = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 79) == 0) begin
                request_lines = req;
                async_reset_pulse();
            end
            cycle(req);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
